// File: rtl/ov7670_capture.sv
// OV7670 parallel capture: registers the sensor pins on pclk, pairs bytes into
// pixels and tags each pixel with frame-buffer address, position and line/frame status.
module ov7670_capture #(
  parameter int RESOLUTION_WIDTH  = 640,
  parameter int RESOLUTION_HEIGHT = 480,
  parameter int BYTES_PER_PIXEL   = 2,
  parameter int ADDR_WIDTH        = $clog2(RESOLUTION_WIDTH * RESOLUTION_HEIGHT)
) (
  input  logic                               pclk,
  input  logic                               rst,
  input  logic                               vsync,
  input  logic                               href,
  input  logic [7:0]                         D,
  output logic [15:0]                        pix_data,
  output logic                               pix_valid,
  output logic [ADDR_WIDTH-1:0]              pix_addr,
  output logic [$clog2(RESOLUTION_WIDTH):0]  pix_x,
  output logic [$clog2(RESOLUTION_HEIGHT):0] pix_y,
  output logic                               frame_start,
  output logic                               frame_done,
  output logic                               frame_err,
  output logic                               line_err
);

  // state      | meaning
  // WAIT_FRAME | out of reset, waiting for the first vsync rise
  // SYNC       | inside the vsync pulse, href ignored
  // ACTIVE     | between vsync pulses, capturing lines

  if (BYTES_PER_PIXEL != 1 && BYTES_PER_PIXEL != 2) begin : g_bpp_illegal
    $error("ov7670_capture: BYTES_PER_PIXEL must be 1 or 2");
  end

  localparam int XW         = $clog2(RESOLUTION_WIDTH) + 1;
  localparam int YW         = $clog2(RESOLUTION_HEIGHT) + 1;
  localparam int LINE_BYTES = RESOLUTION_WIDTH * BYTES_PER_PIXEL;
  localparam int BCW        = $clog2(LINE_BYTES + 2);
  localparam int PCW        = $clog2(RESOLUTION_WIDTH * RESOLUTION_HEIGHT + 1);
  localparam int AIW        = ADDR_WIDTH + 1;
  localparam bit TWO_BYTES  = (BYTES_PER_PIXEL == 2);

  localparam logic [XW-1:0]  X_MAX      = XW'(RESOLUTION_WIDTH);
  localparam logic [YW-1:0]  Y_MAX      = YW'(RESOLUTION_HEIGHT);
  localparam logic [BCW-1:0] BCNT_LINE  = BCW'(LINE_BYTES);
  localparam logic [BCW-1:0] BCNT_SAT   = BCW'(LINE_BYTES + 1);
  localparam logic [PCW-1:0] PIX_TOTAL  = PCW'(RESOLUTION_WIDTH * RESOLUTION_HEIGHT);
  localparam logic [AIW-1:0] LINE_STEP  = AIW'(RESOLUTION_WIDTH);

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    SYNC       = 2'd1,
    ACTIVE     = 2'd2
  } state_t;

  state_t state, state_next;

  logic       vsync_q, vsync_qq;
  logic       href_q, href_qq;
  logic [7:0] d_q;
  logic       vsync_rise, vsync_fall, href_fall;

  logic frame_begin, frame_end, byte_take, line_end;

  logic [XW-1:0]  x_cnt;
  logic [YW-1:0]  y_cnt;
  logic [AIW-1:0] addr_cnt;
  logic [AIW-1:0] line_base;
  logic [PCW-1:0] pix_cnt;
  logic [BCW-1:0] byte_cnt;
  logic           phase;
  logic [7:0]     hi_byte;
  logic           pix_ok;

  always_ff @(posedge pclk) begin
    if (rst) begin
      vsync_q  <= 1'b0;
      vsync_qq <= 1'b0;
      href_q   <= 1'b0;
      href_qq  <= 1'b0;
      d_q      <= 8'h00;
    end else begin
      vsync_q  <= vsync;
      vsync_qq <= vsync_q;
      href_q   <= href;
      href_qq  <= href_q;
      d_q      <= D;
    end
  end

  assign vsync_rise = vsync_q & ~vsync_qq;
  assign vsync_fall = ~vsync_q & vsync_qq;
  assign href_fall  = ~href_q & href_qq;

  always_ff @(posedge pclk) begin
    if (rst) state <= WAIT_FRAME;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      WAIT_FRAME: if (vsync_rise) state_next = SYNC;
      SYNC:       if (vsync_fall) state_next = ACTIVE;
      ACTIVE:     if (vsync_rise) state_next = SYNC;
      default:    state_next = WAIT_FRAME;
    endcase
  end

  // Frame end outranks both byte capture and the href-fall line check.
  always_comb begin
    frame_begin = 1'b0;
    frame_end   = 1'b0;
    byte_take   = 1'b0;
    line_end    = 1'b0;
    case (state)
      SYNC: frame_begin = vsync_fall;
      ACTIVE: begin
        frame_end = vsync_rise;
        byte_take = href_q & ~vsync_rise;
        line_end  = href_fall & ~vsync_rise;
      end
      default: ;
    endcase
  end

  assign pix_ok = (x_cnt < X_MAX) && (y_cnt < Y_MAX);

  always_ff @(posedge pclk) begin
    if (rst) begin
      pix_data    <= 16'h0000;
      pix_valid   <= 1'b0;
      pix_addr    <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      line_err    <= 1'b0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      addr_cnt    <= '0;
      line_base   <= '0;
      pix_cnt     <= '0;
      byte_cnt    <= '0;
      phase       <= 1'b0;
      hi_byte     <= 8'h00;
    end else begin
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      line_err    <= 1'b0;

      if (frame_begin) begin
        frame_start <= 1'b1;
        frame_err   <= 1'b0;
        x_cnt       <= '0;
        y_cnt       <= '0;
        addr_cnt    <= '0;
        line_base   <= '0;
        pix_cnt     <= '0;
        byte_cnt    <= '0;
        phase       <= 1'b0;
      end else if (frame_end) begin
        frame_done <= 1'b1;
        frame_err  <= (pix_cnt != PIX_TOTAL);
        byte_cnt   <= '0;
        phase      <= 1'b0;
      end else if (line_end) begin
        line_err <= (byte_cnt != BCNT_LINE);
        byte_cnt <= '0;
        phase    <= 1'b0;
        x_cnt    <= '0;
        // Next line base is an incremental add; y stops at HEIGHT.
        if (y_cnt < Y_MAX) begin
          y_cnt     <= y_cnt + 1'b1;
          line_base <= line_base + LINE_STEP;
          addr_cnt  <= line_base + LINE_STEP;
        end else begin
          addr_cnt <= line_base;
        end
      end else if (byte_take) begin
        if (byte_cnt != BCNT_SAT) byte_cnt <= byte_cnt + 1'b1;
        if (TWO_BYTES && !phase) begin
          hi_byte <= d_q;
          phase   <= 1'b1;
        end else begin
          phase <= 1'b0;
          if (pix_ok) begin
            pix_valid <= 1'b1;
            pix_data  <= TWO_BYTES ? {hi_byte, d_q} : {8'h00, d_q};
            pix_x     <= x_cnt;
            pix_y     <= y_cnt;
            pix_addr  <= addr_cnt[ADDR_WIDTH-1:0];
            x_cnt     <= x_cnt + 1'b1;
            addr_cnt  <= addr_cnt + 1'b1;
            pix_cnt   <= pix_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ov7670_capture.sv
// Bench for ov7670_capture: two instances (2 and 1 bytes per pixel) share the
// sensor pins and are scored against a line-level reference model.
module tb_ov7670_capture;

  localparam int W = 4;
  localparam int H = 2;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  addr;
    logic [2:0]  x;
    logic [1:0]  y;
  } pix_t;

  logic       pclk = 1'b0;
  logic       rst;
  logic       vsync;
  logic       href;
  logic [7:0] D;

  logic [15:0] pix_data_a, pix_data_b;
  logic        pix_valid_a, pix_valid_b;
  logic [2:0]  pix_addr_a, pix_addr_b;
  logic [2:0]  pix_x_a, pix_x_b;
  logic [1:0]  pix_y_a, pix_y_b;
  logic        frame_start_a, frame_start_b;
  logic        frame_done_a, frame_done_b;
  logic        frame_err_a, frame_err_b;
  logic        line_err_a, line_err_b;

  always #5 pclk = ~pclk;

  ov7670_capture #(.RESOLUTION_WIDTH(W), .RESOLUTION_HEIGHT(H), .BYTES_PER_PIXEL(2)) dut_a (
    .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .D(D),
    .pix_data(pix_data_a), .pix_valid(pix_valid_a), .pix_addr(pix_addr_a),
    .pix_x(pix_x_a), .pix_y(pix_y_a), .frame_start(frame_start_a),
    .frame_done(frame_done_a), .frame_err(frame_err_a), .line_err(line_err_a)
  );

  ov7670_capture #(.RESOLUTION_WIDTH(W), .RESOLUTION_HEIGHT(H), .BYTES_PER_PIXEL(1)) dut_b (
    .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .D(D),
    .pix_data(pix_data_b), .pix_valid(pix_valid_b), .pix_addr(pix_addr_b),
    .pix_x(pix_x_b), .pix_y(pix_y_b), .frame_start(frame_start_b),
    .frame_done(frame_done_b), .frame_err(frame_err_b), .line_err(line_err_b)
  );

  int n_chk = 0;
  int n_fail = 0;

  // observed activity, written only by the monitors
  pix_t obs_q0[$];
  pix_t obs_q1[$];
  int   obs_fs0 = 0, obs_fs1 = 0, obs_fd0 = 0, obs_fd1 = 0;
  int   obs_fe0 = 0, obs_fe1 = 0, obs_le0 = 0, obs_le1 = 0;

  // expected activity, written only by the model
  pix_t exp_q0[$];
  pix_t exp_q1[$];
  int   exp_fs = 0, exp_fd = 0;
  int   exp_fe[2] = '{0, 0};
  int   exp_le[2] = '{0, 0};

  bit armed = 0;
  bit saw_rise = 0;
  int line_idx = 0;
  int pcnt[2] = '{0, 0};
  int rd0 = 0, rd1 = 0;

  always @(negedge pclk) begin : mon_a
    pix_t p;
    if (pix_valid_a) begin
      p.data = pix_data_a; p.addr = pix_addr_a; p.x = pix_x_a; p.y = pix_y_a;
      obs_q0.push_back(p);
    end
    if (frame_start_a) obs_fs0++;
    if (frame_done_a) begin
      obs_fd0++;
      if (frame_err_a) obs_fe0++;
    end
    if (line_err_a) obs_le0++;
  end

  always @(negedge pclk) begin : mon_b
    pix_t p;
    if (pix_valid_b) begin
      p.data = pix_data_b; p.addr = pix_addr_b; p.x = pix_x_b; p.y = pix_y_b;
      obs_q1.push_back(p);
    end
    if (frame_start_b) obs_fs1++;
    if (frame_done_b) begin
      obs_fd1++;
      if (frame_err_b) obs_fe1++;
    end
    if (line_err_b) obs_le1++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: one call per whole line of bytes
  function automatic void model_reset();
    armed = 0;
    saw_rise = 0;
  endfunction

  function automatic void model_line(input logic [7:0] lb[$], input bit line_checked);
    for (int b = 0; b < 2; b++) begin
      int bpp = (b == 0) ? 2 : 1;
      if (armed && line_idx < H) begin
        int npix = lb.size() / bpp;
        if (npix > W) npix = W;
        for (int k = 0; k < npix; k++) begin
          pix_t p;
          p.data = (bpp == 2) ? {lb[2*k], lb[2*k+1]} : {8'h00, lb[k]};
          p.addr = 3'(line_idx * W + k);
          p.x    = 3'(k);
          p.y    = 2'(line_idx);
          if (b == 0) exp_q0.push_back(p);
          else        exp_q1.push_back(p);
        end
        pcnt[b] += npix;
      end
      if (armed && line_checked && lb.size() != W * bpp) exp_le[b]++;
    end
    if (armed) line_idx++;
  endfunction

  function automatic void model_rise();
    if (armed) begin
      exp_fd++;
      for (int b = 0; b < 2; b++) if (pcnt[b] != W * H) exp_fe[b]++;
    end
    armed = 0;
    saw_rise = 1;
  endfunction

  function automatic void model_fall();
    if (saw_rise) begin
      exp_fs++;
      armed = 1;
      line_idx = 0;
      pcnt = '{0, 0};
    end
    saw_rise = 0;
  endfunction

  task automatic compare_pix(input string tag, input pix_t e[$], input pix_t o[$], input int rd);
    check_val({tag, "_count"}, 32'(o.size() - rd), 32'(e.size()));
    for (int i = 0; i < e.size(); i++) begin
      if (rd + i < o.size()) begin
        check_val({tag, "_data"}, 32'(o[rd+i].data), 32'(e[i].data));
        check_val({tag, "_addr"}, 32'(o[rd+i].addr), 32'(e[i].addr));
        check_val({tag, "_x"},    32'(o[rd+i].x),    32'(e[i].x));
        check_val({tag, "_y"},    32'(o[rd+i].y),    32'(e[i].y));
      end
    end
  endtask

  task automatic compare_all();
    compare_pix("bpp2_pix", exp_q0, obs_q0, rd0);
    compare_pix("bpp1_pix", exp_q1, obs_q1, rd1);
    rd0 = obs_q0.size();
    rd1 = obs_q1.size();
    exp_q0.delete();
    exp_q1.delete();
    check_val("bpp2_frame_start", 32'(obs_fs0), 32'(exp_fs));
    check_val("bpp1_frame_start", 32'(obs_fs1), 32'(exp_fs));
    check_val("bpp2_frame_done",  32'(obs_fd0), 32'(exp_fd));
    check_val("bpp1_frame_done",  32'(obs_fd1), 32'(exp_fd));
    check_val("bpp2_frame_err",   32'(obs_fe0), 32'(exp_fe[0]));
    check_val("bpp1_frame_err",   32'(obs_fe1), 32'(exp_fe[1]));
    check_val("bpp2_line_err",    32'(obs_le0), 32'(exp_le[0]));
    check_val("bpp1_line_err",    32'(obs_le1), 32'(exp_le[1]));
    check_val("bpp2_err_cleared", 32'(frame_err_a), 32'(0));
  endtask

  task automatic drive_line(input int n, input bit rnd, input logic [7:0] first,
                            input bit end_vsync, input bit rst_first);
    logic [7:0] lb[$];
    for (int i = 0; i < n; i++) lb.push_back(rnd ? 8'($urandom) : 8'(first + 8'(i)));
    if (rst_first) model_reset();
    model_line(lb, !end_vsync);
    for (int i = 0; i < n; i++) begin
      @(negedge pclk);
      href = 1'b1;
      D    = lb[i];
      rst  = rst_first && (i == 0);
    end
    @(negedge pclk);
    href = 1'b0;
    D    = 8'h00;
    rst  = 1'b0;
    if (end_vsync) begin
      vsync = 1'b1;
      model_rise();
    end else begin
      repeat (4) @(negedge pclk);
    end
  endtask

  task automatic vsync_pulse(input bit noise, input bit already_high);
    if (!already_high) begin
      @(negedge pclk);
      vsync = 1'b1;
      model_rise();
    end
    repeat (2) @(negedge pclk);
    if (noise) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge pclk);
        href = 1'b1;
        D    = 8'($urandom);
      end
      @(negedge pclk);
      href = 1'b0;
    end
    repeat (3) @(negedge pclk);
    vsync = 1'b0;
    model_fall();
    repeat (4) @(negedge pclk);
    compare_all();
  endtask

  initial begin
    rst = 1'b1; vsync = 1'b0; href = 1'b0; D = 8'h00;
    repeat (3) @(negedge pclk);
    check_val("rst_pix_valid",   32'(pix_valid_a),   32'(0));
    check_val("rst_pix_data",    32'(pix_data_a),    32'(0));
    check_val("rst_pix_addr",    32'(pix_addr_a),    32'(0));
    check_val("rst_frame_start", 32'(frame_start_a), 32'(0));
    check_val("rst_frame_done",  32'(frame_done_a),  32'(0));
    check_val("rst_frame_err",   32'(frame_err_a),   32'(0));
    check_val("rst_line_err",    32'(line_err_b),    32'(0));
    rst = 1'b0;
    model_reset();

    // href traffic before the first vsync and inside it is ignored
    drive_line(8, 1, 8'h00, 0, 0);
    vsync_pulse(1, 0);

    // clean frame 0x01..0x10
    drive_line(8, 0, 8'h01, 0, 0);
    drive_line(8, 0, 8'h09, 0, 0);
    vsync_pulse(1, 0);

    // short first line
    drive_line(6, 1, 8'h00, 0, 0);
    drive_line(8, 1, 8'h00, 0, 0);
    vsync_pulse(0, 0);

    // long then odd line, then a clean frame after the dangling byte
    drive_line(10, 1, 8'h00, 0, 0);
    drive_line(7, 1, 8'h00, 0, 0);
    vsync_pulse(0, 0);
    drive_line(8, 0, 8'h21, 0, 0);
    drive_line(8, 0, 8'h29, 0, 0);
    drive_line(8, 1, 8'h00, 0, 0);
    vsync_pulse(0, 0);

    // leave frame_err set, then reset mid-line
    drive_line(6, 1, 8'h00, 0, 0);
    vsync_pulse(0, 0);
    drive_line(6, 1, 8'h00, 0, 0);
    drive_line(8, 1, 8'h00, 0, 1);
    check_val("rst_mid_frame_err", 32'(frame_err_a), 32'(0));
    drive_line(8, 1, 8'h00, 0, 0);
    vsync_pulse(0, 0);
    drive_line(8, 1, 8'h00, 0, 0);
    drive_line(8, 1, 8'h00, 0, 0);
    vsync_pulse(0, 0);

    // href fall coincident with vsync rise
    drive_line(8, 1, 8'h00, 0, 0);
    drive_line(6, 1, 8'h00, 1, 0);
    vsync_pulse(0, 1);

    // single-byte pixels A0..A7
    drive_line(4, 0, 8'hA0, 0, 0);
    drive_line(4, 0, 8'hA4, 0, 0);
    vsync_pulse(0, 0);

    for (int f = 0; f < 8; f++) begin
      int nl = int'($urandom_range(1, 3));
      bit co = ($urandom_range(0, 3) == 0);
      for (int l = 0; l < nl; l++)
        drive_line(int'($urandom_range(3, 10)), 1, 8'h00, co && (l == nl - 1), 0);
      vsync_pulse(bit'($urandom_range(0, 1)), co);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ov7670_capture.md
Name: ov7670_capture

Overview:
- Receiving end of the OV7670 parallel camera interface, sampling on pclk.
- Consumes vsync/href/D from the sensor (or the sensor simulator in benches) and assembles pixel bytes into pixels.
- Emits pixel words with frame-buffer write address and x/y position, plus frame markers and line/frame error flags.
- Sits between the camera pins and the frame buffer / demosaic pipeline.

Parameters:
- RESOLUTION_WIDTH, 640, active pixels per line.
- RESOLUTION_HEIGHT, 480, active lines per frame.
- BYTES_PER_PIXEL, 2, bytes per pixel on D. Legal values are 1 or 2; any other value is a compile-time error.
- ADDR_WIDTH, $clog2(RESOLUTION_WIDTH*RESOLUTION_HEIGHT), width of pix_addr.

Ports:
- pclk  in  1  pixel clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- vsync  in  1  frame sync; active-high pulse between frames.
- href  in  1  high while line bytes are valid on D.
- D  in  8  sensor data; changes on the pclk falling edge.
- pix_data  out  16  assembled pixel; first byte is the high byte. When BYTES_PER_PIXEL=1, pix_data = {8'h00, byte}.
- pix_valid  out  1  one-cycle strobe qualifying pix_data/pix_addr/pix_x/pix_y.
- pix_addr  out  ADDR_WIDTH  linear address y*RESOLUTION_WIDTH+x.
- pix_x  out  $clog2(RESOLUTION_WIDTH)+1  column of the current pixel.
- pix_y  out  $clog2(RESOLUTION_HEIGHT)+1  row of the current pixel.
- frame_start  out  1  one-cycle pulse on the vsync falling edge, once synced.
- frame_done  out  1  one-cycle pulse on the vsync rising edge ending a captured frame.
- frame_err  out  1  valid with frame_done: accepted pixel count != WIDTH*HEIGHT.
- line_err  out  1  one-cycle pulse at href fall: line byte count != WIDTH*BYTES_PER_PIXEL.

Behaviour:
- Input stage: vsync, href and D are registered once (vsync_q, href_q, d_q). vsync edges are detected from vsync_q against its previous value.
- Reset: all outputs 0, counters 0, byte phase 0, state WAIT_FRAME.
- Reset asserted mid-frame aborts the frame immediately. No pix_valid is produced until a full vsync rise then fall is seen.
- State machine:
  - WAIT_FRAME: ignore href. On vsync rise go to SYNC; no frame_done is generated.
  - SYNC: vsync is high; href is ignored. On vsync fall: pulse frame_start, clear x/y/addr/pixel count/phase, go to ACTIVE.
  - ACTIVE: capture bytes while href_q=1. On vsync rise: pulse frame_done, set frame_err, go to SYNC.
- Byte assembly (ACTIVE, href_q=1), BYTES_PER_PIXEL=2:
  - Phase 0 latches d_q as the high byte.
  - Phase 1 forms {hi, d_q}.
  - If x < WIDTH and y < HEIGHT, register the pixel and assert pix_valid on the next edge.
  - Phase toggles on every accepted byte.
- BYTES_PER_PIXEL=1: every byte is one pixel.
- Latency: pix_valid is high in the cycle after the edge that follows the low byte being sampled, i.e. 2 rising edges after the low byte is on D.
- pix_x/pix_y/pix_addr carry the position of the pixel being strobed. After each strobe, x and addr increment.
- Overflow:
  - Bytes beyond WIDTH*BYTES_PER_PIXEL in a line are counted but produce no pix_valid.
  - Lines beyond HEIGHT produce no pix_valid.
- href fall in ACTIVE:
  - Pulse line_err if the line byte count != WIDTH*BYTES_PER_PIXEL (this includes an odd count, i.e. phase left at 1).
  - Discard any dangling high byte.
  - Set x=0, phase=0, y+=1, addr=y_new*WIDTH (computed incrementally, no multiplier).
  - The line byte count clears to 0.
- frame_err=1 if accepted pixels != WIDTH*HEIGHT. It is held until the next frame_start, then cleared.
- Counters saturate at their maximum (y at HEIGHT+1 is sufficient) and never wrap within a frame.
- href high while in SYNC or WAIT_FRAME: ignored, no line_err.
- vsync rise while href_q is high: the frame ends. The partial line is dropped without line_err.
- vsync rise and href fall in the same cycle: the frame end takes priority; no line_err.

Test Plan:
- Benches use WIDTH=4, HEIGHT=2 unless stated otherwise.
- Clean frame: after reset, vsync pulse, then 2 lines of 8 bytes 0x01..0x10, then vsync pulse → 1 frame_start; 8 pix_valid with data 0x0102,0x0304,…,0x0F10 and addr 0..7 (x 0..3, y 0..1); frame_done with frame_err=0; line_err never asserted.
- Mid-frame reset: rst for 1 cycle during line 0 with href high → no pix_valid until the next vsync rise+fall; the next frame starts at addr 0.
- Short line: line 0 has 6 bytes, line 1 has 8 → 3 pixels in line 0 and line_err pulse at its href fall; line 1 pixels at addr 4..7; frame_err=1 (7 pixels).
- Long/odd lines: line 0 has 10 bytes → 4 pixels plus line_err. Line 1 has 7 bytes → 3 pixels plus line_err; the trailing byte is dropped and the next frame's first pixel uses the first byte as high byte.
- Sync gating: href toggled with bytes while vsync is high, and before the first vsync after reset → zero pix_valid, zero line_err, no frame_done for the first vsync.
- BYTES_PER_PIXEL=1 with WIDTH=4, HEIGHT=2 and bytes 0xA0..0xA7 → pix_data 0x00A0..0x00A7, addr 0..7, frame_err=0.
